// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage buffer.
//   PC_W_DEF / INST_W_DEF : default field widths
//   NOP_INST_DEF          : default bubble instruction (all zero)
//   STALL_MAX             : saturation value of the stall counter
//   stage_rec_t           : one stage entry {valid, pc, inst} at default widths
package pipe_pkg;
  localparam int PC_W_DEF = 32;
  localparam int INST_W_DEF = 32;
  localparam logic [INST_W_DEF-1:0] NOP_INST_DEF = '0;
  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  typedef struct packed {
    logic                  valid;
    logic [PC_W_DEF-1:0]   pc;
    logic [INST_W_DEF-1:0] inst;
  } stage_rec_t;
endpackage

// File: rtl/stage_entry.sv
// Single valid+payload slot.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : drop the entry (same effect as reset, used for flush)
//   load       : capture d_pc/d_inst and mark valid
//   unload     : mark empty (payload left as is, it is never observed)
//   valid/pc/inst : registered slot contents
// Priority: rst/clr over load over unload.
module stage_entry
  import pipe_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int INST_W = INST_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic              unload,
  input  logic [PC_W-1:0]   d_pc,
  input  logic [INST_W-1:0] d_inst,
  output logic              valid,
  output logic [PC_W-1:0]   pc,
  output logic [INST_W-1:0] inst
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      valid <= 1'b0;
      pc    <= '0;
      inst  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= d_pc;
      inst  <= d_inst;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage buffer between fetch-like producer and consumer.
//   clk, rst          : clock, synchronous active-high reset
//   flush             : drop all held and incoming entries this cycle
//   in_valid/in_ready : upstream handshake, in_pc/in_inst payload
//   out_valid/out_ready : downstream handshake, out_pc/out_inst payload
//   stall_cnt         : saturating count of cycles with out_valid & !out_ready
//
// Handshake: a transfer happens at a rising edge when valid and ready are
// both 1 on that side. valid never depends on ready of the same side; once
// out_valid is raised the payload is held stable until consumed or flushed.
//
// SKID=1: main + skid entry, in_ready comes straight from a flop.
// SKID=0: main entry only, in_ready = !out_valid | out_ready.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int                PC_W     = PC_W_DEF,
  parameter int                INST_W   = INST_W_DEF,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_DEF),
  parameter int                SKID     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [15:0]       stall_cnt
);

  logic              accept;
  logic              main_free;
  logic              main_v;
  logic [PC_W-1:0]   main_pc;
  logic [INST_W-1:0] main_inst;
  logic              main_load;
  logic              main_unload;
  logic [PC_W-1:0]   main_d_pc;
  logic [INST_W-1:0] main_d_inst;

  assign accept    = in_valid & in_ready;
  // Main entry can take new data when empty or being consumed this edge.
  assign main_free = ~main_v | out_ready;

  stage_entry #(.PC_W(PC_W), .INST_W(INST_W)) u_main (
    .clk    (clk),
    .rst    (rst),
    .clr    (flush),
    .load   (main_load),
    .unload (main_unload),
    .d_pc   (main_d_pc),
    .d_inst (main_d_inst),
    .valid  (main_v),
    .pc     (main_pc),
    .inst   (main_inst)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic              skid_v;
      logic [PC_W-1:0]   skid_pc;
      logic [INST_W-1:0] skid_inst;
      logic              skid_load;
      logic              skid_unload;
      logic              sel_skid;
      logic              in_ready_q;

      // Skid always drains into main first, so an entry accepted while the
      // skid is moving goes behind it (into skid) to keep FIFO order.
      always_comb begin
        main_load   = 1'b0;
        main_unload = 1'b0;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        sel_skid    = 1'b0;
        if (main_free) begin
          if (skid_v) begin
            main_load = 1'b1;
            sel_skid  = 1'b1;
            if (accept) skid_load = 1'b1;
            else        skid_unload = 1'b1;
          end else if (accept) begin
            main_load = 1'b1;
          end else begin
            main_unload = 1'b1;
          end
        end else if (accept) begin
          skid_load = 1'b1;
        end
      end

      assign main_d_pc   = sel_skid ? skid_pc : in_pc;
      assign main_d_inst = sel_skid ? skid_inst : in_inst;

      stage_entry #(.PC_W(PC_W), .INST_W(INST_W)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .clr    (flush),
        .load   (skid_load),
        .unload (skid_unload),
        .d_pc   (in_pc),
        .d_inst (in_inst),
        .valid  (skid_v),
        .pc     (skid_pc),
        .inst   (skid_inst)
      );

      // Dedicated flop tracking !skid_v so in_ready has no combinational path.
      always_ff @(posedge clk) begin
        if (rst || flush)     in_ready_q <= 1'b1;
        else if (skid_load)   in_ready_q <= 1'b0;
        else if (skid_unload) in_ready_q <= 1'b1;
      end

      assign in_ready = in_ready_q;
    end else begin : g_single
      assign in_ready    = main_free;
      assign main_load   = accept;
      assign main_unload = main_free & ~accept;
      assign main_d_pc   = in_pc;
      assign main_d_inst = in_inst;
    end
  endgenerate

  assign out_valid = main_v;
  assign out_pc    = main_v ? main_pc : '0;
  assign out_inst  = main_v ? main_inst : NOP_INST;

  // Not cleared by flush: it measures backpressure over the whole run.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (main_v && !out_ready && stall_cnt != STALL_MAX) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [15:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  pipe_stage_buf #(.PC_W(32), .INST_W(32), .NOP_INST(32'h0), .SKID(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .stall_cnt (stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // one rising edge, then settle; outputs are sampled and inputs driven here
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input stage_rec_t r);
    in_valid = r.valid;
    in_pc    = r.pc;
    in_inst  = r.inst;
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_pc"}, 64'(out_pc), 64'd0);
    check({tag, "_inst"}, 64'(out_inst), 64'd0);
  endtask

  stage_rec_t idle = '{valid: 1'b0, pc: 32'h0, inst: 32'h0};
  stage_rec_t va   = '{valid: 1'b1, pc: 32'h200, inst: 32'h0000_0A11};
  stage_rec_t vb   = '{valid: 1'b1, pc: 32'h204, inst: 32'h0000_0B22};
  stage_rec_t vc   = '{valid: 1'b1, pc: 32'h208, inst: 32'h0000_0C33};

  initial begin
    int seen;
    logic [63:0] e;

    // reset
    rst = 1'b1;
    step();
    step();
    check_empty("rst");
    check("rst_stall", 64'(stall_cnt), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;

    // single entry latency
    out_ready = 1'b1;
    offer('{valid: 1'b1, pc: 32'h100, inst: 32'h0050_0093});
    step();
    offer(idle);
    check("lat_valid", 64'(out_valid), 64'd1);
    check("lat_pc", 64'(out_pc), 64'h100);
    check("lat_inst", 64'(out_inst), 64'h0050_0093);
    step();
    check_empty("lat_drain");

    // A,B,C back to back with out_ready=0
    out_ready = 1'b0;
    offer(va); step();
    offer(vb); step();
    offer(vc); step();
    check("abc_main_pc", 64'(out_pc), 64'(va.pc));
    check("abc_main_inst", 64'(out_inst), 64'(va.inst));
    check("abc_in_ready", 64'(in_ready), 64'd0);
    check("abc_stall", 64'(stall_cnt), 64'd2);
    out_ready = 1'b1;      // C still offered
    step();
    check("abc_b_pc", 64'(out_pc), 64'(vb.pc));
    check("abc_b_inst", 64'(out_inst), 64'(vb.inst));
    check("abc_in_ready_back", 64'(in_ready), 64'd1);
    step();
    offer(idle);
    check("abc_c_pc", 64'(out_pc), 64'(vc.pc));
    check("abc_c_inst", 64'(out_inst), 64'(vc.inst));
    step();
    check_empty("abc_drain");

    // flush with both entries full and a same-cycle offer
    out_ready = 1'b0;
    offer('{valid: 1'b1, pc: 32'h300, inst: 32'h0000_0D44}); step();
    offer('{valid: 1'b1, pc: 32'h304, inst: 32'h0000_0E55}); step();
    check("fl_full_in_ready", 64'(in_ready), 64'd0);
    check("fl_full_valid", 64'(out_valid), 64'd1);
    flush = 1'b1;
    offer('{valid: 1'b1, pc: 32'h400, inst: 32'h0000_0F66});
    step();
    flush = 1'b0;
    offer(idle);
    check_empty("fl_next");
    check("fl_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    step();
    check_empty("fl_no_ghost");
    check("fl_stall", 64'(stall_cnt), 64'd4);

    // stream 100 entries with out_ready=1
    seen = 0;
    for (int k = 0; k < 101; k++) begin
      if (k < 100) begin
        in_valid = 1'b1;
        in_pc    = 32'h1000 + 32'(k) * 32'd4;
        in_inst  = 32'hA500_0000 + 32'(k);
        exp_q.push_back({in_pc, in_inst});
      end else begin
        offer(idle);
      end
      step();
      check("str_in_ready", 64'(in_ready), 64'd1);
      if (out_valid) begin
        seen++;
        if (exp_q.size() == 0) begin
          check("str_extra", {out_pc, out_inst}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("str_data", {out_pc, out_inst}, e);
        end
      end
    end
    check("str_count", 64'(seen), 64'd100);
    check("str_left", 64'(exp_q.size()), 64'd0);
    check("str_stall", 64'(stall_cnt), 64'd4);

    // stall counter saturation
    out_ready = 1'b0;
    offer('{valid: 1'b1, pc: 32'h500, inst: 32'h0000_1177});
    step();
    offer(idle);
    for (int k = 0; k < 70000; k++) step();
    check("sat_stall", 64'(stall_cnt), 64'hFFFF);
    check("sat_held_pc", 64'(out_pc), 64'h500);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("sat_after_flush", 64'(stall_cnt), 64'hFFFF);
    check_empty("sat_flush");

    // reset and flush together with a full block
    offer('{valid: 1'b1, pc: 32'h600, inst: 32'h0000_2288}); step();
    offer('{valid: 1'b1, pc: 32'h604, inst: 32'h0000_3399}); step();
    check("rf_full_in_ready", 64'(in_ready), 64'd0);
    rst   = 1'b1;
    flush = 1'b1;
    offer('{valid: 1'b1, pc: 32'h608, inst: 32'h0000_44AA});
    step();
    rst   = 1'b0;
    flush = 1'b0;
    offer(idle);
    check_empty("rf");
    check("rf_stall", 64'(stall_cnt), 64'd0);
    check("rf_in_ready", 64'(in_ready), 64'd1);
    step();
    check_empty("rf_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
